pipe_stage_skid: RTL and testbench

//  Parametrised successor to the CPU's fixed FD/DX/XM/MW/PW stage latches.
//  One generic inter-stage latch with valid/ready handshake and a 2-entry skid buffer.
//  It also provides synchronous flush and bubble (NOP) insertion when empty.
//  It folds in the exception-to-instruction rewrite so a stage can hold on a

---
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// pipe_stage_skid : falling-edge inter-stage latch, valid/ready, 2-entry skid,
//                   flush, NOP bubble output and exception-to-IR rewrite.
// Revision: 1.0
// ============================================================================
module pipe_stage_skid #(
   parameter int               IR_W       = 32,
   parameter int               DATA_W     = 32,
   parameter int               NUM_OPS    = 3,
   parameter logic [IR_W-1:0]  NOP_IR     = '0,
   parameter logic [4:0]       EXC_OPCODE = 5'b10101
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IR_W-1:0]           in_ir,
   input  logic [NUM_OPS*DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0]         in_exc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [IR_W-1:0]           out_ir,
   output logic [NUM_OPS*DATA_W-1:0] out_data,
   output logic [1:0]                occupancy
);

   localparam int PW = NUM_OPS * DATA_W;
   localparam int EW = IR_W - 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state;
   logic [IR_W-1:0] head_ir;
   logic [PW-1:0]   head_data;
   logic [IR_W-1:0] skid_ir;
   logic [PW-1:0]   skid_data;
   logic            ready_q;

   logic [EW-1:0]   exc_field;
   logic [IR_W-1:0] store_ir;
   logic            push;
   logic            pop;

   generate
      if (IR_W < 6 || NUM_OPS < 1) begin : g_width_check
         $error("pipe_stage_skid: IR_W must be >= 6 and NUM_OPS >= 1");
      end
      if (DATA_W >= EW) begin : g_exc_trunc
         assign exc_field = in_exc[EW-1:0];
      end else begin : g_exc_ext
         assign exc_field = {{(EW-DATA_W){1'b0}}, in_exc};
      end
   endgenerate

   // Rewrite is applied before the entry is stored, so head and skid see the same IR.
   assign store_ir  = (|in_exc) ? {EXC_OPCODE, exc_field} : in_ir;
   assign push      = in_valid & ready_q;
   assign pop       = out_valid & out_ready;

   assign in_ready  = ready_q;
   assign out_valid = (state != EMPTY);
   assign out_ir    = head_ir;
   assign out_data  = head_data;
   assign occupancy = state;

   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         ready_q   <= 1'b1;
         head_ir   <= NOP_IR;
         head_data <= '0;
         skid_ir   <= NOP_IR;
         skid_data <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         ready_q   <= 1'b1;
         head_ir   <= NOP_IR;
         head_data <= '0;
         skid_ir   <= NOP_IR;
         skid_data <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  state     <= ONE;
                  head_ir   <= store_ir;
                  head_data <= in_data;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state     <= FULL;
                  ready_q   <= 1'b0;
                  skid_ir   <= store_ir;
                  skid_data <= in_data;
               end else if (push && pop) begin
                  head_ir   <= store_ir;
                  head_data <= in_data;
               end else if (pop) begin
                  // Head is cleared so an empty stage presents a bubble directly.
                  state     <= EMPTY;
                  head_ir   <= NOP_IR;
                  head_data <= '0;
               end
            end
            FULL: begin
               if (pop) begin
                  state     <= ONE;
                  ready_q   <= 1'b1;
                  head_ir   <= skid_ir;
                  head_data <= skid_data;
                  skid_ir   <= NOP_IR;
                  skid_data <= '0;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_skid : scoreboard bench driving two shared-stimulus instances
//                      (32b x3 operands and 16b x4 operands).
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_skid;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] exc;
      logic [95:0] data;
   } ent_t;

   logic        clock = 1'b1;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_ir = '0;
   logic [95:0] in_data = '0;
   logic [31:0] in_exc = '0;

   logic        in_ready1, out_valid1, in_ready2, out_valid2;
   logic [31:0] out_ir1, out_ir2;
   logic [95:0] out_data1;
   logic [63:0] out_data2;
   logic [1:0]  occ1, occ2;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   pipe_stage_skid #(.IR_W(32), .DATA_W(32), .NUM_OPS(3)) dut1 (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_ir(in_ir),
      .in_data(in_data), .in_exc(in_exc),
      .out_valid(out_valid1), .out_ready(out_ready), .out_ir(out_ir1),
      .out_data(out_data1), .occupancy(occ1)
   );

   pipe_stage_skid #(.IR_W(32), .DATA_W(16), .NUM_OPS(4)) dut2 (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .in_ir(in_ir),
      .in_data(in_data[63:0]), .in_exc(in_exc[15:0]),
      .out_valid(out_valid2), .out_ready(out_ready), .out_ir(out_ir2),
      .out_data(out_data2), .occupancy(occ2)
   );

   function automatic logic [31:0] xir(input logic [31:0] ir, input logic [31:0] exc);
      return (exc != 32'h0) ? {5'b10101, exc[26:0]} : ir;
   endfunction

   function automatic logic [95:0] data_of(input logic [31:0] ir);
      return {ir ^ 32'hD0D0_0000, ir ^ 32'hC0C0_0000, ir ^ 32'hB0B0_0000};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] e_ir1, e_ir2;
      logic [95:0] e_d;
      int          n;
      n = q.size();
      if (n > 0) begin
         e_ir1 = xir(q[0].ir, q[0].exc);
         e_ir2 = xir(q[0].ir, {16'h0, q[0].exc[15:0]});
         e_d   = q[0].data;
      end else begin
         e_ir1 = 32'h0;
         e_ir2 = 32'h0;
         e_d   = '0;
      end
      check({tag, ".occ1"},   128'(occ1),       128'(n));
      check({tag, ".rdy1"},   128'(in_ready1),  128'(n != 2));
      check({tag, ".vld1"},   128'(out_valid1), 128'(n != 0));
      check({tag, ".ir1"},    128'(out_ir1),    128'(e_ir1));
      check({tag, ".data1"},  128'(out_data1),  128'(e_d));
      check({tag, ".occ2"},   128'(occ2),       128'(n));
      check({tag, ".rdy2"},   128'(in_ready2),  128'(n != 2));
      check({tag, ".vld2"},   128'(out_valid2), 128'(n != 0));
      check({tag, ".ir2"},    128'(out_ir2),    128'(e_ir2));
      check({tag, ".data2"},  128'(out_data2),  128'(e_d[63:0]));
   endtask

   // One cycle: drive after the rising edge, model and check just after the falling edge.
   task automatic step(input string tag, input logic v, input logic [31:0] ir,
                       input logic [31:0] exc, input logic ordy, input logic fl);
      int   pre;
      ent_t e;
      @(posedge clock);
      in_valid  = v;
      in_ir     = ir;
      in_exc    = exc;
      in_data   = data_of(ir);
      out_ready = ordy;
      flush     = fl;
      @(negedge clock);
      pre = q.size();
      if (!reset || fl) begin
         q.delete();
      end else begin
         if (pre > 0 && ordy) void'(q.pop_front());
         if (v && pre < 2) begin
            e.ir   = ir;
            e.exc  = exc;
            e.data = data_of(ir);
            q.push_back(e);
         end
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset held low while upstream offers
      in_valid = 1'b1;
      in_ir    = 32'h99;
      #1 reset = 1'b0;
      #1 check_all("rst_async");
      step("rst_hold_a", 1'b1, 32'h99, 32'h0, 1'b1, 1'b0);
      step("rst_hold_b", 1'b1, 32'h98, 32'h0, 1'b0, 1'b0);
      @(posedge clock);
      in_valid = 1'b0;
      reset    = 1'b1;

      // Streaming
      step("stream_11", 1'b1, 32'h11, 32'h0, 1'b1, 1'b0);
      step("stream_22", 1'b1, 32'h22, 32'h0, 1'b1, 1'b0);
      step("stream_33", 1'b1, 32'h33, 32'h0, 1'b1, 1'b0);
      step("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Stall and skid, including a refused offer while full
      step("skid_a1", 1'b1, 32'hA1, 32'h0, 1'b0, 1'b0);
      step("skid_a2", 1'b1, 32'hA2, 32'h0, 1'b0, 1'b0);
      step("skid_refused", 1'b1, 32'h5A, 32'h0, 1'b0, 1'b0);
      step("skid_pop1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step("skid_pop2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Exception rewrite in head and in skid; high-only exc is invisible to the 16b instance
      step("exc_head", 1'b1, 32'h40, 32'h3, 1'b0, 1'b0);
      check("exc_ir_const", 128'(out_ir1), 128'(32'hA800_0003));
      step("exc_skid", 1'b1, 32'h41, 32'h0012_0000, 1'b0, 1'b0);
      step("exc_pop1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step("exc_pop2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush while full with a push offered, then flush against a push into ONE
      step("fl_c1", 1'b1, 32'hC1, 32'h0, 1'b0, 1'b0);
      step("fl_c2", 1'b1, 32'hC2, 32'h0, 1'b0, 1'b0);
      step("fl_full", 1'b1, 32'hBB, 32'h0, 1'b1, 1'b1);
      step("fl_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step("fl_d1", 1'b1, 32'hD1, 32'h0, 1'b0, 1'b0);
      step("fl_one", 1'b1, 32'hD2, 32'h0, 1'b0, 1'b1);
      step("fl_d3", 1'b1, 32'hD3, 32'h0, 1'b1, 1'b0);
      step("fl_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset pulse between edges while full
      step("ar_e1", 1'b1, 32'hE1, 32'h0, 1'b0, 1'b0);
      step("ar_e2", 1'b1, 32'hE2, 32'h0, 1'b0, 1'b0);
      @(posedge clock);
      in_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      q.delete();
      check_all("ar_pulse");
      #1 reset = 1'b1;
      step("ar_f1", 1'b1, 32'hF1, 32'h0, 1'b0, 1'b0);
      step("ar_f2", 1'b1, 32'hF2, 32'h0, 1'b1, 1'b0);
      step("ar_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
